// File: rtl/cond_ex_stage.sv
// -----------------------------------------------------------------------------
// cond_ex_stage
//   Execute-stage condition unit and EX/MEM pipeline register. Holds the
//   architectural NZCV flags. Evaluates each instruction's ARM condition field
//   against those held flags, not against the ALU's fresh flags. Gates the
//   instruction's side effects by the result, then registers the gated
//   controls and the datapath into the MEM stage.
//
//   Optional feature macro: CONDEX_PERF_CNT_EN
//     This macro adds a saturating counter of instructions squashed by their
//     condition. The counter drives the SquashCnt output.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Stall             hold flags, M register and counter
//   FlushE            kill the instruction in E (ignored while Stall=1)
//   ValidE            E holds a real instruction
//   CondE             ARM condition field
//   FlagWriteE        [1] update N,Z   [0] update C,V
//   ALUFlags          {N,Z,C,V} from the ALU
//   PCSrcE .. MemtoRegE  ungated decode controls
//   ALUResultE, WriteDataE, WA3E  datapath into the M register
//   BranchTakenE      combinational taken-branch indication
//   FlagsQ            current {N,Z,C,V}
//   PCSrcM .. WA3M    registered gated controls / datapath
//   SquashCnt         squash counter (CONDEX_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module cond_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              FlushE,
  input  logic              ValidE,
  input  logic [3:0]        CondE,
  input  logic [1:0]        FlagWriteE,
  input  logic [3:0]        ALUFlags,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemtoRegE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WA3E,
  output logic              BranchTakenE,
  output logic [3:0]        FlagsQ,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_W-1:0]  WA3M
`ifdef CONDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  SquashCnt
`endif
);

  logic [3:0]        flags_r;
  logic              pcsrc_r;
  logic              regwrite_r;
  logic              memwrite_r;
  logic              memtoreg_r;
  logic [DATA_W-1:0] aluout_r;
  logic [DATA_W-1:0] wdata_r;
  logic [REG_W-1:0]  wa3_r;
  logic              cond_ex_s;
  logic              live_s;
  logic              n_s;
  logic              z_s;
  logic              c_s;
  logic              v_s;

  assign n_s = flags_r[3];
  assign z_s = flags_r[2];
  assign c_s = flags_r[1];
  assign v_s = flags_r[0];

  // Condition check against the architectural flags; 1111 behaves like AL
  always_comb begin
    cond_ex_s = 1'b0;
    case (CondE)
      4'b0000: cond_ex_s = z_s;
      4'b0001: cond_ex_s = ~z_s;
      4'b0010: cond_ex_s = c_s;
      4'b0011: cond_ex_s = ~c_s;
      4'b0100: cond_ex_s = n_s;
      4'b0101: cond_ex_s = ~n_s;
      4'b0110: cond_ex_s = v_s;
      4'b0111: cond_ex_s = ~v_s;
      4'b1000: cond_ex_s = c_s & ~z_s;
      4'b1001: cond_ex_s = ~c_s | z_s;
      4'b1010: cond_ex_s = (n_s == v_s);
      4'b1011: cond_ex_s = (n_s != v_s);
      4'b1100: cond_ex_s = ~z_s & (n_s == v_s);
      4'b1101: cond_ex_s = z_s | (n_s != v_s);
      4'b1110: cond_ex_s = 1'b1;
      default: cond_ex_s = 1'b1;
    endcase
  end

  assign live_s       = ValidE & ~FlushE & cond_ex_s;
  assign BranchTakenE = PCSrcE & live_s;

  // Architectural flags: per-pair partial update by live instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (~Stall & live_s) begin
      if (FlagWriteE[1]) flags_r[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) flags_r[1:0] <= ALUFlags[1:0];
    end
  end

  // EX/MEM register: the gated controls qualify the unconditionally loaded data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcsrc_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      aluout_r   <= {DATA_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      wa3_r      <= {REG_W{1'b0}};
    end else if (~Stall) begin
      pcsrc_r    <= PCSrcE    & live_s;
      regwrite_r <= RegWriteE & live_s;
      memwrite_r <= MemWriteE & live_s;
      memtoreg_r <= MemtoRegE & live_s;
      aluout_r   <= ALUResultE;
      wdata_r    <= WriteDataE;
      wa3_r      <= WA3E;
    end
  end

  assign FlagsQ     = flags_r;
  assign PCSrcM     = pcsrc_r;
  assign RegWriteM  = regwrite_r;
  assign MemWriteM  = memwrite_r;
  assign MemtoRegM  = memtoreg_r;
  assign ALUOutM    = aluout_r;
  assign WriteDataM = wdata_r;
  assign WA3M       = wa3_r;

`ifdef CONDEX_PERF_CNT_EN
  logic [CNT_W-1:0] squash_r;

  // Saturating count of real, unflushed instructions that failed their condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash_r <= {CNT_W{1'b0}};
    end else if (~Stall & ValidE & ~FlushE & ~cond_ex_s & (squash_r != {CNT_W{1'b1}})) begin
      squash_r <= squash_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign SquashCnt = squash_r;
`else
  logic unused_cnt_w_s;
  assign unused_cnt_w_s = ^CNT_W;
`endif

endmodule

// File: tb/tb_cond_ex_stage.sv
module tb_cond_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              Stall, FlushE, ValidE;
  logic [3:0]        CondE;
  logic [1:0]        FlagWriteE;
  logic [3:0]        ALUFlags;
  logic              PCSrcE, RegWriteE, MemWriteE, MemtoRegE;
  logic [DATA_W-1:0] ALUResultE, WriteDataE;
  logic [REG_W-1:0]  WA3E;
  logic              BranchTakenE;
  logic [3:0]        FlagsQ;
  logic              PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [DATA_W-1:0] ALUOutM, WriteDataM;
  logic [REG_W-1:0]  WA3M;
`ifdef CONDEX_PERF_CNT_EN
  logic [CNT_W-1:0]  SquashCnt;
`endif

  cond_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .FlushE(FlushE), .ValidE(ValidE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .BranchTakenE(BranchTakenE), .FlagsQ(FlagsQ),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M)
`ifdef CONDEX_PERF_CNT_EN
    , .SquashCnt(SquashCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, kept as plain named values
  logic              m_n, m_z, m_c, m_v;
  logic              m_pc, m_rw, m_mw, m_m2r;
  logic [DATA_W-1:0] m_alu, m_wd;
  logic [REG_W-1:0]  m_wa3;
  int                m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM condition semantics from the mnemonic table: pairs differ only in cond[0] (inverse)
  function automatic logic cond_model(input logic [3:0] c);
    logic base;
    if (c[3:1] == 3'd7) return 1'b1;
    case (c[3:1])
      3'd0: base = m_z;
      3'd1: base = m_c;
      3'd2: base = m_n;
      3'd3: base = m_v;
      3'd4: base = m_c && !m_z;
      3'd5: base = (m_n == m_v);
      default: base = !m_z && (m_n == m_v);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    {m_pc, m_rw, m_mw, m_m2r} = 4'b0000;
    m_alu = '0; m_wd = '0; m_wa3 = '0; m_cnt = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".flags"}, {60'd0, FlagsQ}, {60'd0, m_n, m_z, m_c, m_v});
    check({tag, ".pcsrcm"}, {63'd0, PCSrcM}, {63'd0, m_pc});
    check({tag, ".regwritem"}, {63'd0, RegWriteM}, {63'd0, m_rw});
    check({tag, ".memwritem"}, {63'd0, MemWriteM}, {63'd0, m_mw});
    check({tag, ".memtoregm"}, {63'd0, MemtoRegM}, {63'd0, m_m2r});
    check({tag, ".aluoutm"}, {32'd0, ALUOutM}, {32'd0, m_alu});
    check({tag, ".wdatam"}, {32'd0, WriteDataM}, {32'd0, m_wd});
    check({tag, ".wa3m"}, {60'd0, WA3M}, {60'd0, m_wa3});
`ifdef CONDEX_PERF_CNT_EN
    check({tag, ".squash"}, {62'd0, SquashCnt}, 64'(m_cnt));
`endif
  endtask

  // One clock: check the combinational branch output, advance the model, check registers
  task automatic step(input string tag);
    logic ok, live;
    @(negedge clk);
    ok   = cond_model(CondE);
    live = ValidE && !FlushE && ok;
    check({tag, ".branch"}, {63'd0, BranchTakenE}, {63'd0, PCSrcE && live});
    if (!Stall) begin
      if (live && FlagWriteE[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
      if (live && FlagWriteE[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
      m_pc  = PCSrcE && live;
      m_rw  = RegWriteE && live;
      m_mw  = MemWriteE && live;
      m_m2r = MemtoRegE && live;
      m_alu = ALUResultE; m_wd = WriteDataE; m_wa3 = WA3E;
      if (ValidE && !FlushE && !ok && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    @(posedge clk); #1;
    check_state(tag);
  endtask

  task automatic set_instr(input logic v, input logic [3:0] c, input logic [1:0] fw,
                           input logic [3:0] af, input logic pc, input logic rw);
    ValidE = v; CondE = c; FlagWriteE = fw; ALUFlags = af; PCSrcE = pc; RegWriteE = rw;
    MemWriteE = 1'b0; MemtoRegE = 1'b0;
    ALUResultE = $urandom; WriteDataE = $urandom; WA3E = REG_W'($urandom);
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; FlushE = 1'b0;
    set_instr(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1; check_state("reset");
    @(negedge clk); reset = 1'b0;
    #1;

    // CMP sets Z, then EQ executes and NE is squashed
    set_instr(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0); step("cmp");
    set_instr(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1); step("eq");
    check("eq.rw_taken", {63'd0, RegWriteM}, 64'd1);
    set_instr(1'b1, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1); step("ne");
    check("ne.rw_squashed", {63'd0, RegWriteM}, 64'd0);

    // Partial flag write: N,Z only
    set_instr(1'b1, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0); step("clr");
    set_instr(1'b1, 4'b1110, 2'b10, 4'b1011, 1'b0, 1'b0); step("nz_only");
    check("nz_only.value", {60'd0, FlagsQ}, 64'h8);

    // GT taken branch with N=V=1, Z=0
    set_instr(1'b1, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0); step("set1001");
    set_instr(1'b1, 4'b1100, 2'b00, 4'b0000, 1'b1, 1'b1); step("gt");
    check("gt.pcsrcm", {63'd0, PCSrcM}, 64'd1);

    // Stall beats flush, then flush inserts a bubble
    Stall = 1'b1; FlushE = 1'b1;
    set_instr(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b1, 1'b1); step("stall0");
    set_instr(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b1, 1'b1); step("stall1");
    Stall = 1'b0;
    set_instr(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b1, 1'b1); step("flush");
    check("flush.bubble", {60'd0, PCSrcM, RegWriteM, MemWriteM, MemtoRegM}, 64'd0);
    FlushE = 1'b0;

    // Asynchronous reset mid-cycle, during stall+flush
    set_instr(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1); step("pre_rst");
    Stall = 1'b1; FlushE = 1'b1;
    #2; reset = 1'b1; #1;
    model_reset();
    check_state("async_rst");
    #1; reset = 1'b0; Stall = 1'b0; FlushE = 1'b0;

    // Failed conditions with flags all clear; a bubble in between must not count
    set_instr(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1); step("sq1");
    set_instr(1'b1, 4'b0100, 2'b00, 4'b0000, 1'b0, 1'b1); step("sq2");
    set_instr(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1); step("bubble");
    set_instr(1'b1, 4'b0010, 2'b00, 4'b0000, 1'b0, 1'b1); step("sq3");
    set_instr(1'b1, 4'b0110, 2'b00, 4'b0000, 1'b0, 1'b1); step("sq4");
    set_instr(1'b1, 4'b1000, 2'b00, 4'b0000, 1'b0, 1'b1); step("sq5");
`ifdef CONDEX_PERF_CNT_EN
    check("sq.saturated", {62'd0, SquashCnt}, 64'd3);
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      Stall  = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      set_instr($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom));
      MemWriteE = 1'($urandom); MemtoRegE = 1'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
